// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W       = 7;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 4;

  // Bits needed to hold a streak count of 0..max inclusive.
  function automatic int streak_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int W = streak_w(MAX_D_STREAK);

  logic [W-1:0] r_cnt;

  assign o_sat = (r_cnt == W'(MAX_D_STREAK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && !o_sat)  r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between fetch (read-only) and data
// ports; data wins conflicts until its streak saturates, then fetch gets a slot.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  logic              w_sat;
  logic              w_i_gnt, w_d_gnt;
  owner_t            r_owner, w_owner_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_unused;

  assign w_unused = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (rst_n) begin
      if (d_req && (!i_req || !w_sat)) w_d_gnt = 1'b1;
      else if (i_req)                  w_i_gnt = 1'b1;
    end
  end

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  always_comb begin
    mem_read    = w_i_gnt | (w_d_gnt & ~d_we);
    mem_write   = w_d_gnt & d_we;
    mem_addr    = r_addr;
    mem_in      = r_wdata;
    w_owner_nxt = OWN_NONE;
    if (w_i_gnt) begin
      mem_addr    = i_addr[ADDR_W-1:0];
      w_owner_nxt = OWN_I;
    end else if (w_d_gnt) begin
      mem_addr = d_addr[ADDR_W-1:0];
      if (d_we) mem_in = d_wdata;
      else      w_owner_nxt = OWN_D;
    end
  end

  // Address/data registers simply track the bus so idle cycles hold last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_addr  <= mem_addr;
      r_wdata <= mem_in;
    end
  end

  arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_d_gnt & i_req),
    .i_clr (w_i_gnt | ~i_req),
    .o_sat (w_sat)
  );

  assign i_rvalid = (r_owner == OWN_I);
  assign d_rvalid = (r_owner == OWN_D);
  assign i_rdata  = mem_out;
  assign d_rdata  = mem_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word-addressed memory model, grant model and a
// response scoreboard checked every cycle.
module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [31:0]   i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Byte-addressed, word-organised memory: address[6:2] selects the word.
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] sh  [0:31];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[6:2]] <= mem_in;
    if (mem_read)  mem_out <= mem[mem_addr[6:2]];
  end

  typedef struct {
    int            due;
    bit            is_i;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   mon_ei, mon_ed;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_streak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_arb(input bit ir, input bit dr, output bit gi, output bit gd);
    gi = ir && (!dr || m_streak == MS);
    gd = dr && !gi;
    if (gi || !ir)              m_streak = 0;
    else if (gd && m_streak < MS) m_streak++;
  endtask

  task automatic push_rsp(input bit is_i, input logic [31:0] a);
    exp_t e;
    e.due  = cyc + 1;
    e.is_i = is_i;
    e.data = sh[a[6:2]];
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard: every cycle, rvalids must match exactly what is due.
  always @(negedge clk) begin
    mon_ei = 1'b0;
    mon_ed = 1'b0;
    mon_e.data = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e  = q.pop_front();
      mon_ei = mon_e.is_i;
      mon_ed = !mon_e.is_i;
    end
    n_chk++;
    if (i_rvalid !== mon_ei) begin
      n_fail++;
      $display("FAIL i_rvalid cyc=%0d got=%b exp=%b", cyc, i_rvalid, mon_ei);
    end
    n_chk++;
    if (d_rvalid !== mon_ed) begin
      n_fail++;
      $display("FAIL d_rvalid cyc=%0d got=%b exp=%b", cyc, d_rvalid, mon_ed);
    end
    if (mon_ei) begin
      n_chk++;
      if (i_rdata !== mon_e.data) begin
        n_fail++;
        $display("FAIL i_rdata cyc=%0d got=%h exp=%h", cyc, i_rdata, mon_e.data);
      end
    end
    if (mon_ed) begin
      n_chk++;
      if (d_rdata !== mon_e.data) begin
        n_fail++;
        $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, mon_e.data);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 32'h04; d_addr = 32'h10; d_wdata = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({i_gnt, d_gnt, mem_read, mem_write} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs got=%b exp=0000", {i_gnt, d_gnt, mem_read, mem_write});
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1 rst_n = 1'b1;
    m_streak = 0;
    tick();
  endtask

  task automatic test_fetch_only();
    bit gi, gd;
    i_req = 1'b1; i_addr = 32'h04;
    @(negedge clk);
    model_arb(1'b1, 1'b0, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt, mem_read, mem_write} !== {gi, gd, 2'b10}) begin
      n_fail++;
      $display("FAIL fetch_grant got=%b exp=%b", {i_gnt, d_gnt, mem_read, mem_write}, {gi, gd, 2'b10});
    end
    n_chk++;
    if (mem_addr !== 7'h04) begin
      n_fail++;
      $display("FAIL fetch_addr got=%h exp=04", mem_addr);
    end
    push_rsp(1'b1, i_addr);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b0, gi, gd);
    tick();
  endtask

  task automatic test_conflict();
    bit gi, gd;
    logic [9:0] seq_i;
    seq_i = 10'b10_0001_0000;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0C; d_addr = 32'h08;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      model_arb(1'b1, 1'b1, gi, gd);
      n_chk++;
      if ({i_gnt, d_gnt} !== {seq_i[k], !seq_i[k]}) begin
        n_fail++;
        $display("FAIL conflict_grant k=%0d got=%b exp=%b", k, {i_gnt, d_gnt}, {seq_i[k], !seq_i[k]});
      end
      n_chk++;
      if (mem_addr !== (seq_i[k] ? 7'h0C : 7'h08)) begin
        n_fail++;
        $display("FAIL conflict_addr k=%0d got=%h", k, mem_addr);
      end
      push_rsp(seq_i[k], seq_i[k] ? i_addr : d_addr);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b0, gi, gd);
    tick();
  endtask

  task automatic test_write_read();
    bit gi, gd;
    int wr_pulses;
    wr_pulses = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678;
    @(negedge clk);
    model_arb(1'b0, 1'b1, gi, gd);
    if (mem_write === 1'b1) wr_pulses++;
    n_chk++;
    if ({d_gnt, mem_read, mem_write} !== 3'b101 || mem_addr !== 7'h10 || mem_in !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_drive got gnt/rd/wr=%b addr=%h in=%h exp 101/10/12345678",
               {d_gnt, mem_read, mem_write}, mem_addr, mem_in);
    end
    sh[4] = 32'h12345678;
    tick();
    d_we = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b1, gi, gd);
    if (mem_write === 1'b1) wr_pulses++;
    n_chk++;
    if ({d_gnt, mem_read, mem_write} !== 3'b110) begin
      n_fail++;
      $display("FAIL read_drive got=%b exp=110", {d_gnt, mem_read, mem_write});
    end
    push_rsp(1'b0, d_addr);
    tick();
    d_req = 1'b0; d_addr = 32'h7C; d_wdata = 32'hFFFFFFFF; d_we = 1'b1;
    @(negedge clk);
    model_arb(1'b0, 1'b0, gi, gd);
    if (mem_write === 1'b1) wr_pulses++;
    n_chk++;
    if (mem_addr !== 7'h10 || mem_in !== 32'h12345678 || {mem_read, mem_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_hold got addr=%h in=%h rd/wr=%b exp 10/12345678/00",
               mem_addr, mem_in, {mem_read, mem_write});
    end
    n_chk++;
    if (wr_pulses != 1) begin
      n_fail++;
      $display("FAIL write_pulses got=%0d exp=1", wr_pulses);
    end
    d_we = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit gi, gd;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
    @(negedge clk);
    model_arb(1'b0, 1'b1, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_d_grant got=%b exp=01", {i_gnt, d_gnt});
    end
    push_rsp(1'b0, d_addr);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0C;
    @(negedge clk);
    model_arb(1'b1, 1'b0, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b10 || mem_addr !== 7'h0C) begin
      n_fail++;
      $display("FAIL b2b_i_grant got=%b addr=%h exp=10/0C", {i_gnt, d_gnt}, mem_addr);
    end
    push_rsp(1'b1, i_addr);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b0, gi, gd);
    tick();
  endtask

  task automatic test_reset_mid();
    bit gi, gd;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h0C; d_addr = 32'h08;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_arb(1'b1, 1'b1, gi, gd);
      n_chk++;
      if ({i_gnt, d_gnt} !== 2'b01) begin
        n_fail++;
        $display("FAIL rstmid_pre k=%0d got=%b exp=01", k, {i_gnt, d_gnt});
      end
      if (k < 3) begin
        push_rsp(1'b0, d_addr);
        tick();
      end
    end
    // Fourth data read is in flight here; reset must swallow it.
    #1 rst_n = 1'b0;
    m_streak = 0;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({i_gnt, d_gnt, mem_read, mem_write} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rstmid_outputs got=%b exp=0000", {i_gnt, d_gnt, mem_read, mem_write});
      end
    end
    #1 rst_n = 1'b1;
    #1;
    model_arb(1'b1, 1'b1, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt} !== {gi, gd}) begin
      n_fail++;
      $display("FAIL rstmid_streak got=%b exp=%b", {i_gnt, d_gnt}, {gi, gd});
    end
    push_rsp(1'b0, d_addr);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b0, gi, gd);
    tick();
  endtask

  task automatic test_withdraw();
    bit gi, gd;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08; i_req = 1'b1; i_addr = 32'h0C;
    @(negedge clk);
    model_arb(1'b1, 1'b1, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b01 || mem_addr !== 7'h08) begin
      n_fail++;
      $display("FAIL withdraw_grant got=%b addr=%h exp=01/08", {i_gnt, d_gnt}, mem_addr);
    end
    push_rsp(1'b0, d_addr);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    model_arb(1'b0, 1'b1, gi, gd);
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL withdraw_after got=%b exp=01", {i_gnt, d_gnt});
    end
    push_rsp(1'b0, d_addr);
    tick();
    d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      model_arb(1'b0, 1'b0, gi, gd);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'hA500_0000 | i;
      sh[i]  = 32'hA500_0000 | i;
    end
    mem[1] = 32'hDEADBEEF;
    sh[1]  = 32'hDEADBEEF;

    test_reset();
    test_fetch_only();
    test_conflict();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_withdraw();

    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
